// File: rtl/id_ex_pipe.sv
// id_ex_pipe: elastic ID/EX pipeline register with valid/ready handshake.
//
// Storage is a 2-entry FIFO built from a main slot and a skid slot. The main slot
// drives the out_* ports. The skid slot absorbs one extra bundle after execute
// stalls. A flush squashes both slots. A saturating counter records how many
// cycles a valid bundle waited on execute.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      decode-side handshake
//   in_op1, in_op2           register-read operands
//   in_concat_zero           zero-extended immediate
//   in_sign_ext_imd          sign-extended immediate
//   in_rs, in_rt             source register indices
//   in_wb, in_mem, in_ex     WB / MEM / EX control groups
//   flush                    squash all held bundles
//   out_valid / out_ready    execute-side handshake
//   out_*                    registered bundle (main slot)
//   occupancy                number of held bundles (0..2)
//   stall_cnt                saturating count of out_valid && !out_ready cycles
module id_ex_pipe #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 4,
    parameter int unsigned EX_W   = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_op1,
    input  logic [DATA_W-1:0] in_op2,
    input  logic [DATA_W-1:0] in_concat_zero,
    input  logic [DATA_W-1:0] in_sign_ext_imd,
    input  logic [REG_AW-1:0] in_rs,
    input  logic [REG_AW-1:0] in_rt,
    input  logic              in_wb,
    input  logic              in_mem,
    input  logic [EX_W-1:0]   in_ex,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_op1,
    output logic [DATA_W-1:0] out_op2,
    output logic [DATA_W-1:0] out_concat_zero,
    output logic [DATA_W-1:0] out_sign_ext_imd,
    output logic [REG_AW-1:0] out_rs,
    output logic [REG_AW-1:0] out_rt,
    output logic              out_wb,
    output logic              out_mem,
    output logic [EX_W-1:0]   out_ex,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int unsigned BundleW = 4 * DATA_W + 2 * REG_AW + 2 + EX_W;
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic [BundleW-1:0] in_bundle;
    logic [BundleW-1:0] main_data_q, main_data_d;
    logic [BundleW-1:0] skid_data_q, skid_data_d;
    logic               main_valid_q, main_valid_d;
    logic               skid_valid_q, skid_valid_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic               accept;
    logic               consume;

    assign in_bundle = {in_op1, in_op2, in_concat_zero, in_sign_ext_imd,
                        in_rs, in_rt, in_wb, in_mem, in_ex};

    // in_ready depends only on state, so out_ready never reaches it combinationally.
    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && in_ready && !flush;
    assign consume  = main_valid_q && out_ready;

    always_comb begin
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;

        if (flush) begin
            main_data_d  = '0;
            skid_data_d  = '0;
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q) begin
            // Skid is never occupied while main is empty.
            if (accept) begin
                main_data_d  = in_bundle;
                main_valid_d = 1'b1;
            end
        end else if (consume) begin
            if (skid_valid_q) begin
                main_data_d  = skid_data_q;
                skid_data_d  = '0;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_data_d  = in_bundle;
            end else begin
                // Zero the drained slot so execute sees a clean bubble.
                main_data_d  = '0;
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_data_d  = in_bundle;
            skid_valid_d = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_valid_q && !out_ready && (stall_cnt_q != CntMax)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_data_q  <= '0;
            skid_data_q  <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign {out_op1, out_op2, out_concat_zero, out_sign_ext_imd,
            out_rs, out_rt, out_wb, out_mem, out_ex} = main_data_q;

    assign out_valid = main_valid_q;
    assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
    assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/id_ex_pipe.md
# id_ex_pipe

Parametrised, elastic ID/EX pipeline register for the 16-bit pipeline core. It replaces a bare clocked latch with a valid/ready handshake, a 2-entry skid buffer, a synchronous flush for branch and hazard squash, and a saturating stall-cycle counter. It sits between decode/register-read and execute, and carries operands, immediates, source register indices and the WB/MEM/EX control groups.

## Interface
Parameters:
- DATA_W, 16, width of each operand and immediate field
- REG_AW, 4, width of each source-register index
- EX_W, 2, width of the EX control group
- CNT_W, 16, width of the stall counter

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decode presents a valid bundle
- in_ready  out  1  stage can accept a bundle this cycle
- in_op1, in_op2  in  DATA_W  register-read operands
- in_concat_zero, in_sign_ext_imd  in  DATA_W  zero-extended and sign-extended immediates
- in_rs, in_rt  in  REG_AW  source register indices
- in_wb, in_mem  in  1  WB and MEM control bits
- in_ex  in  EX_W  EX control group (full width carried; no truncation)
- flush  in  1  squash all held bundles
- out_valid  out  1  output bundle valid
- out_ready  in  1  execute consumes the bundle this cycle
- out_op1, out_op2, out_concat_zero, out_sign_ext_imd, out_rs, out_rt, out_wb, out_mem, out_ex  out  match the corresponding inputs  registered bundle
- occupancy  out  2  number of held bundles, 0 to 2
- stall_cnt  out  CNT_W  saturating count of stalled cycles

## Operation
- Storage is two slots: main (drives the out_* ports) and skid. Each slot has its own valid bit.
- in_ready = !skid_valid. It comes straight from a register, with no combinational path from out_ready.
- accept = in_valid && in_ready && !flush. consume = out_valid && out_ready.
- Slot update rules, evaluated in priority order:
  - flush: both valids cleared; all bundle fields, including the control bits, are zeroed; the input is dropped.
  - main empty, accept: bundle is loaded into main.
  - main full, consume, skid full: skid moves into main and skid is cleared. in_ready was 0, so no accept is possible in this case.
  - main full, consume, skid empty, accept: bundle is loaded into main.
  - main full, consume, no accept: main valid is cleared. Main data is zeroed so that downstream sees a clean bubble.
  - main full, no consume, accept: bundle is loaded into skid.
  - otherwise: slots hold their contents.
- Ordering is strict FIFO. No bundle is ever duplicated or lost except under flush or reset.
- occupancy = main_valid + skid_valid.
- stall_cnt increments by 1 on every cycle with out_valid && !out_ready. It saturates at 2^CNT_W-1. It is cleared only by rst; flush does not clear it.

## Timing
- Reset: while rst is high at a clock edge, every output register takes value 0 (out_valid, all out_* fields, occupancy, stall_cnt). in_ready reads 1. Inputs are ignored during reset. Reset asserted mid-transfer discards both held slots.
- Latency: a bundle accepted at edge N into an empty stage is visible on out_* with out_valid=1 after edge N, which is 1 cycle.
- Throughput: 1 bundle per cycle while out_ready=1.
- Backpressure: one extra bundle is absorbed after out_ready falls. in_ready falls in the cycle after the skid slot fills.
- Recovery: in_ready rises in the cycle after the skid slot drains into main.
- flush takes priority over a simultaneous accept and a simultaneous consume. The consume handshake still completes on the execute side; the stage only clears its own state. out_valid=0 in the cycle after flush.
- Simultaneous flush and rst: the reset values apply.

## Test plan
- Reset then stream: assert rst for 2 cycles, then send op1=16'h0001..16'h0005 on consecutive cycles with out_ready=1 -> out_valid from cycle 1, outputs 0001..0005 in order, occupancy stays 1, stall_cnt=0.
- Backpressure fill: with out_ready=0, send A=16'h1111 then B=16'h2222 -> out_op1=1111, occupancy=2, in_ready=0. A third bundle C is held off. Raise out_ready -> outputs A, B, C in order with none lost. stall_cnt counts exactly the cycles where out_valid=1 and out_ready=0.
- Flush with full slots: occupancy=2 and a new bundle presented, then flush=1 -> next cycle out_valid=0, occupancy=0, out_wb=out_mem=0, out_ex=0, in_ready=1. The presented bundle is never output.
- Field width: set EX_W=3 and in_ex=3'b101 -> out_ex=3'b101. Set in_sign_ext_imd=16'hFFF0 and in_rs=4'hF -> both pass through unchanged.
- Stall counter saturation: set CNT_W=4 and hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 and stays there. A flush leaves it at 15; rst clears it to 0.
- Reset mid-transfer: occupancy=2, assert rst for 1 cycle -> all outputs 0, in_ready=1. Subsequent traffic contains no stale bundle.
